fetch_stage: RTL

- Fetch stage of the 5-stage MIPS pipeline. Holds the F-stage PC, issues instruction-memory requests, and owns the F/D pipeline register.
- Consumes pc_next from the next-PC unit. That unit's branch/jump decisions come from the instruction currently in D, and the design uses delay slots.
- Supports a variable-latency instruction memory with one request outstanding, hazard stalls, and an exception/eret redirect (flush).

---
 rtl/fetch_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS F stage: PC, imem request/response handshake, F/D register (FETCH_ADEL_EN adds fetch address check)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] F_pc,
    output logic        f_wait,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic        D_valid,
    output logic [4:0]  D_exc_code
);

`ifdef FETCH_ADEL_EN
    localparam bit ADEL_EN = 1'b1;
`else
    localparam bit ADEL_EN = 1'b0;
`endif

    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state;
    logic [31:0] hold_buf;
    logic        adel_pend;
    logic [4:0]  d_exc_q;

    logic        avail;
    logic        fire;
    logic [31:0] src;
    logic        issue_ok;
    logic        next_ok;

    function automatic logic addr_ok(input logic [31:0] a);
        return !ADEL_EN || ((a[1:0] == 2'b00) && (a >= IM_LO) && (a <= IM_HI));
    endfunction

    always_comb begin
        avail    = ((state == S_WAIT) && im_rvalid) || (state == S_HOLD);
        src      = (state == S_HOLD) ? hold_buf : im_rdata;
        fire     = avail && !stall && !flush;
        issue_ok = addr_ok(F_pc);
        next_ok  = addr_ok(pc_next);
        f_wait   = !avail;
        // A flush cycle never issues, so a redirect cannot leave a stale request in flight.
        im_req   = !flush && (((state == S_ISSUE) && issue_ok) || (fire && next_ok));
        im_addr  = (state == S_ISSUE) ? F_pc : pc_next;
    end

    assign D_exc_code = ADEL_EN ? d_exc_q : 5'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_ISSUE;
            F_pc      <= RESET_PC;
            hold_buf  <= 32'h0;
            adel_pend <= 1'b0;
            D_pc      <= RESET_PC;
            D_instr   <= 32'h0;
            D_valid   <= 1'b0;
            d_exc_q   <= 5'd0;
        end else if (flush) begin
            F_pc      <= flush_pc;
            D_pc      <= flush_pc;
            D_instr   <= 32'h0;
            D_valid   <= 1'b0;
            d_exc_q   <= 5'd0;
            hold_buf  <= 32'h0;
            adel_pend <= 1'b0;
            // A response still owed by memory must be swallowed before re-issuing.
            if (((state == S_WAIT) || (state == S_DROP)) && !im_rvalid)
                state <= S_DROP;
            else
                state <= S_ISSUE;
        end else if (fire) begin
            D_instr   <= src;
            D_pc      <= F_pc;
            D_valid   <= 1'b1;
            d_exc_q   <= adel_pend ? EXC_ADEL : 5'd0;
            F_pc      <= pc_next;
            if (next_ok) begin
                adel_pend <= 1'b0;
                state     <= S_WAIT;
            end else begin
                hold_buf  <= 32'h0;
                adel_pend <= 1'b1;
                state     <= S_HOLD;
            end
        end else begin
            case (state)
                S_ISSUE: begin
                    if (issue_ok) begin
                        state <= S_WAIT;
                    end else begin
                        hold_buf  <= 32'h0;
                        adel_pend <= 1'b1;
                        state     <= S_HOLD;
                    end
                end
                S_WAIT: begin
                    if (im_rvalid) begin
                        hold_buf <= im_rdata;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD:  state <= S_HOLD;
                S_DROP: begin
                    if (im_rvalid)
                        state <= S_ISSUE;
                end
                default: state <= S_ISSUE;
            endcase
        end
    end

endmodule
